// File: rtl/serial_word_rx.sv
// Framed serial receiver: start(1), WIDTH data bits LSB first, even parity, stop(0).
// Good words land in a single holding register with a valid/ready handshake.
module serial_word_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        par_d        = par_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                par_d = 1'b0;
                if (in)
                    state_d = S_DATA;
            end
            S_DATA: begin
                // shift in at the MSB so the first (LSB) bit ends up at bit 0
                sr_d  = {in, sr_q[WIDTH-1:1]};
                par_d = par_q ^ in;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_PAR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PAR: begin
                par_d   = par_q ^ in;
                state_d = S_STOP;
            end
            S_STOP: begin
                // a high stop bit is consumed here, never reused as a start bit
                state_d = S_IDLE;
                if (in)
                    frame_err_d = 1'b1;
                else if (par_q)
                    parity_err_d = 1'b1;
                else if (!out_valid_q || out_ready) begin
                    out_d       = sr_q;
                    out_valid_d = 1'b1;
                end else
                    overrun_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            par_q        <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            par_q        <= par_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx at WIDTH=8, 2 and 16.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_serial_word_rx;

    logic        clk;
    logic        reset;
    logic        in8, in2, in16;
    logic        rdy8, rdy2, rdy16;
    logic [7:0]  out8;
    logic [1:0]  out2;
    logic [15:0] out16;
    logic        v8, v2, v16;
    logic        pe8, pe2, pe16;
    logic        fe8, fe2, fe16;
    logic        ov8, ov2, ov16;

    int total = 0;
    int bad   = 0;

    serial_word_rx #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in(in8), .out_ready(rdy8), .out(out8),
        .out_valid(v8), .parity_err(pe8), .frame_err(fe8), .overrun(ov8));

    serial_word_rx #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .in(in2), .out_ready(rdy2), .out(out2),
        .out_valid(v2), .parity_err(pe2), .frame_err(fe2), .overrun(ov2));

    serial_word_rx #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in(in16), .out_ready(rdy16), .out(out16),
        .out_valid(v16), .parity_err(pe16), .frame_err(fe16), .overrun(ov16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one serial bit on the selected instance, advance to the next falling edge
    task automatic drive_bit(input int sel, input logic b);
        in8  = (sel == 0) ? b : 1'b0;
        in2  = (sel == 1) ? b : 1'b0;
        in16 = (sel == 2) ? b : 1'b0;
        @(negedge clk);
    endtask

    task automatic body(input int sel, input int w, input logic [15:0] d, input logic flip);
        logic p;
        p = flip;
        drive_bit(sel, 1'b1);
        for (int i = 0; i < w; i++) begin
            drive_bit(sel, d[i]);
            p = p ^ d[i];
        end
        drive_bit(sel, p);
    endtask

    task automatic send(input int sel, input int w, input logic [15:0] d,
                        input logic flip, input logic stop);
        body(sel, w, d, flip);
        drive_bit(sel, stop);
    endtask

    initial begin
        logic any;
        reset = 1'b1;
        in8 = 1'b0; in2 = 1'b0; in16 = 1'b0;
        rdy8 = 1'b1; rdy2 = 1'b1; rdy16 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out8", 32'(out8), 0);
        chk("rst_v8", 32'(v8), 0);
        chk("rst_pe8", 32'(pe8), 0);
        chk("rst_fe8", 32'(fe8), 0);
        chk("rst_ov8", 32'(ov8), 0);
        chk("rst_v2", 32'(v2), 0);
        chk("rst_v16", 32'(v16), 0);
        reset = 1'b0;
        @(negedge clk);

        // good frame 0xA5
        body(0, 8, 16'h00A5, 1'b0);
        chk("a5_not_early", 32'(v8), 0);
        drive_bit(0, 1'b0);
        chk("a5_valid", 32'(v8), 1);
        chk("a5_out", 32'(out8), 32'hA5);
        chk("a5_pe", 32'(pe8), 0);
        chk("a5_fe", 32'(fe8), 0);
        chk("a5_ov", 32'(ov8), 0);
        drive_bit(0, 1'b0);
        chk("a5_one_cycle", 32'(v8), 0);

        // parity flipped
        send(0, 8, 16'h00A5, 1'b1, 1'b0);
        chk("par_pe", 32'(pe8), 1);
        chk("par_v", 32'(v8), 0);
        chk("par_fe", 32'(fe8), 0);
        drive_bit(0, 1'b0);
        chk("par_pulse_end", 32'(pe8), 0);

        // bad stop bit: only frame_err, and the high stop is not a new start
        send(0, 8, 16'h00A5, 1'b0, 1'b1);
        chk("stop_fe", 32'(fe8), 1);
        chk("stop_pe", 32'(pe8), 0);
        chk("stop_v", 32'(v8), 0);
        any = 1'b0;
        repeat (14) begin
            drive_bit(0, 1'b0);
            any = any | v8 | pe8 | fe8 | ov8;
        end
        chk("stop_no_spurious", 32'(any), 0);

        // overrun with no consumer
        rdy8 = 1'b0;
        send(0, 8, 16'h003C, 1'b0, 1'b0);
        chk("ovr_first_v", 32'(v8), 1);
        chk("ovr_first_out", 32'(out8), 32'h3C);
        send(0, 8, 16'h0081, 1'b0, 1'b0);
        chk("ovr_pulse", 32'(ov8), 1);
        chk("ovr_out_kept", 32'(out8), 32'h3C);
        chk("ovr_v_kept", 32'(v8), 1);
        drive_bit(0, 1'b0);
        chk("ovr_pulse_end", 32'(ov8), 0);
        chk("ovr_still_held", 32'(out8), 32'h3C);
        rdy8 = 1'b1;
        drive_bit(0, 1'b0);
        chk("ovr_drain", 32'(v8), 0);

        // consume and load on the same edge
        rdy8 = 1'b0;
        send(0, 8, 16'h003C, 1'b0, 1'b0);
        chk("swap_first", 32'(out8), 32'h3C);
        body(0, 8, 16'h0081, 1'b0);
        rdy8 = 1'b1;
        drive_bit(0, 1'b0);
        chk("swap_out", 32'(out8), 32'h81);
        chk("swap_v", 32'(v8), 1);
        chk("swap_ov", 32'(ov8), 0);
        drive_bit(0, 1'b0);
        chk("swap_drain", 32'(v8), 0);

        // reset after the 4th data bit, then a clean 0x5A
        rdy8 = 1'b0;
        send(0, 8, 16'h003C, 1'b0, 1'b0);
        repeat (5) drive_bit(0, 1'b1);
        reset = 1'b1;
        in8 = 1'b0;
        #1;
        chk("midrst_out", 32'(out8), 0);
        chk("midrst_v", 32'(v8), 0);
        @(negedge clk);
        chk("midrst_pulses", 32'({pe8, fe8, ov8}), 0);
        reset = 1'b0;
        send(0, 8, 16'h005A, 1'b0, 1'b0);
        chk("post_rst_v", 32'(v8), 1);
        chk("post_rst_out", 32'(out8), 32'h5A);
        chk("post_rst_err", 32'({pe8, fe8, ov8}), 0);
        rdy8 = 1'b1;
        drive_bit(0, 1'b0);

        // idle line
        any = 1'b0;
        repeat (100) begin
            drive_bit(0, 1'b0);
            any = any | v8 | pe8 | fe8 | ov8;
        end
        chk("idle_quiet", 32'(any), 0);

        // WIDTH=2
        body(1, 2, 16'h0002, 1'b0);
        chk("w2_not_early", 32'(v2), 0);
        drive_bit(1, 1'b0);
        chk("w2_valid", 32'(v2), 1);
        chk("w2_out", 32'(out2), 32'h2);
        chk("w2_err", 32'({pe2, fe2, ov2}), 0);
        drive_bit(1, 1'b0);
        chk("w2_drain", 32'(v2), 0);

        // WIDTH=16
        body(2, 16, 16'hBEEF, 1'b0);
        chk("w16_not_early", 32'(v16), 0);
        drive_bit(2, 1'b0);
        chk("w16_valid", 32'(v16), 1);
        chk("w16_out", 32'(out16), 32'hBEEF);
        chk("w16_err", 32'({pe16, fe16, ov16}), 0);
        drive_bit(2, 1'b0);
        chk("w16_drain", 32'(v16), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
